// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: double-buffered, blanked scan controller for a multiplexed 7-segment display
// Ports: clk, reset (sync, active-high), enable (scan run), digits_in (packed BCD, digit 0 in [3:0]),
//   load (capture strobe) -> bcd_out (decoder nibble), digit_sel (one-hot enable), digit_idx,
//   frame_done (last SHOW cycle of top digit), busy (not idle).
// Optional leading-zero blanking: define BCD_SCAN_LZ_BLANK_EN.
module bcd_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic                          load,
  output logic [3:0]                    bcd_out,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done,
  output logic                          busy
);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int CMAX = PRESCALE > BLANK_CYCLES ? PRESCALE : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx_n;
  logic [4*NUM_DIGITS-1:0] pending, pending_n, active, active_n;
  logic xfer, last, show;
`ifdef BCD_SCAN_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] mask, mask_n;
  logic z;
`endif
  // outputs are registered from next-state values so they line up with the state register
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = digit_idx;
    xfer      = 1'b0;
    last      = digit_idx == IW'(NUM_DIGITS - 1);
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else if (state == IDLE) begin
      state_n = BLANK;
      cnt_n   = CW'(BLANK_CYCLES - 1);
      idx_n   = '0;
      xfer    = 1'b1;
    end else if (cnt != '0) begin
      cnt_n = cnt - 1'b1;
    end else if (state == BLANK) begin
      state_n = SHOW;
      cnt_n   = CW'(PRESCALE - 1);
    end else begin
      state_n = BLANK;
      cnt_n   = CW'(BLANK_CYCLES - 1);
      idx_n   = last ? '0 : digit_idx + 1'b1;
      xfer    = last;
    end
    // a load coinciding with a transfer bypasses straight into the active buffer
    pending_n = load ? digits_in : pending;
    active_n  = xfer ? pending_n : active;
`ifdef BCD_SCAN_LZ_BLANK_EN
    mask_n = mask;
    z      = 1'b1;
    if (xfer) begin
      mask_n[0] = 1'b0;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
        z         = z & (active_n[4*k +: 4] == 4'd0);
        mask_n[k] = z;
      end
    end
    show = state_n == SHOW && !mask_n[idx_n];
`else
    show = state_n == SHOW;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      digit_idx  <= '0;
      pending    <= '0;
      active     <= '0;
      bcd_out    <= '0;
      digit_sel  <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
`ifdef BCD_SCAN_LZ_BLANK_EN
      mask       <= '0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      digit_idx  <= idx_n;
      pending    <= pending_n;
      active     <= active_n;
      bcd_out    <= state_n == BLANK ? active_n[4*idx_n +: 4] : bcd_out;
      digit_sel  <= show ? NUM_DIGITS'(1) << idx_n : '0;
      frame_done <= state_n == SHOW && cnt_n == '0 && idx_n == IW'(NUM_DIGITS - 1);
      busy       <= state_n != IDLE;
`ifdef BCD_SCAN_LZ_BLANK_EN
      mask       <= mask_n;
`endif
    end
  end
endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb_bcd_scan_ctrl: randomized self-checking bench for bcd_scan_ctrl against a frame-timeline model
module tb_bcd_scan_ctrl;
  localparam int N = 4, P = 4, B = 1, S = B + P, FRAME = N * S;
  logic clk = 0, reset = 1, enable = 0, load = 0;
  logic [15:0] digits_in = '0;
  logic [3:0] bcd_out, digit_sel;
  logic [1:0] digit_idx;
  logic frame_done, busy;
  int tests = 0, fails = 0;
  bit m_run;
  int m_t;
  logic [15:0] m_pend, m_act;
  logic [3:0] m_bcd, e_sel;
  logic [1:0] e_idx;
  logic e_fd, e_busy;

  bcd_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .enable(enable), .digits_in(digits_in), .load(load),
    .bcd_out(bcd_out), .digit_sel(digit_sel), .digit_idx(digit_idx),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] obs();
    return {bcd_out, digit_sel, digit_idx, frame_done, busy};
  endfunction

  function automatic logic [12:0] exp_v();
    return {m_bcd, e_sel, e_idx, e_fd, e_busy};
  endfunction

  function automatic bit suppressed(int d);
`ifdef BCD_SCAN_LZ_BLANK_EN
    return d > 0 && (m_act >> (4 * d)) == 16'd0;
`else
    return 1'b0;
`endif
  endfunction

  // time since scan start decides digit and phase; frames latch the pending value at each frame start
  task automatic step();
    int pos, d;
    @(posedge clk);
    if (reset) begin
      m_run = 0; m_t = 0; m_pend = '0; m_act = '0; m_bcd = '0;
    end else begin
      if (load) m_pend = digits_in;
      if (!enable) m_run = 0;
      else if (!m_run) begin m_run = 1; m_t = 0; m_act = m_pend; end
      else begin m_t++; if (m_t % FRAME == 0) m_act = m_pend; end
    end
    if (m_run) begin
      pos = m_t % S; d = (m_t / S) % N;
      e_idx = 2'(d); e_busy = 1;
      if (pos < B) begin
        e_sel = '0; e_fd = 0; m_bcd = m_act[4*d +: 4];
      end else begin
        e_sel = suppressed(d) ? 4'b0 : 4'(1 << d);
        e_fd = (d == N - 1) && (pos == S - 1);
      end
    end else begin
      e_sel = '0; e_idx = '0; e_fd = 0; e_busy = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; enable = 0; load = 0;
    step(); step();
    tests++;
    if (obs() !== 13'd0) begin fails++; $display("FAIL reset: outputs got %b want 0", obs()); end
    reset = 0;
  endtask

  task automatic test_scan();
    int last_fd = -1, nfd = 0;
    logic [3:0] seen = '0;
    digits_in = 16'h1234; load = 1;
    step();
    load = 0; enable = 1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      seen |= digit_sel;
      tests++;
      if (obs() !== exp_v()) begin fails++; $display("FAIL scan: got %b want %b", obs(), exp_v()); end
      if (frame_done) begin
        if (last_fd >= 0) begin
          tests++;
          if (i - last_fd != FRAME) begin fails++; $display("FAIL frame_period: got %0d want %0d", i - last_fd, FRAME); end
        end
        last_fd = i; nfd++;
      end
    end
    tests++;
    if (nfd < 2) begin fails++; $display("FAIL frame_count: got %0d want >=2", nfd); end
`ifndef BCD_SCAN_LZ_BLANK_EN
    tests++;
    if (seen !== 4'b1111) begin fails++; $display("FAIL scan_digits: got %b want 1111", seen); end
`endif
  endtask

  task automatic test_midframe_load();
    bit found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      tests++;
      if (obs() !== exp_v()) begin fails++; $display("FAIL midload_wait: got %b want %b", obs(), exp_v()); end
      found = digit_idx == 2'd1 && digit_sel != 0;
    end
    tests++;
    if (!found) begin fails++; $display("FAIL midload_timeout: got none want digit 1 SHOW"); end
    digits_in = 16'h5678; load = 1;
    step();
    load = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tests++;
      if (obs() !== exp_v()) begin fails++; $display("FAIL midload: got %b want %b", obs(), exp_v()); end
      step();
    end
  endtask

  task automatic test_bypass();
    bit found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      tests++;
      if (obs() !== exp_v()) begin fails++; $display("FAIL bypass_wait: got %b want %b", obs(), exp_v()); end
      found = frame_done;
    end
    tests++;
    if (!found) begin fails++; $display("FAIL bypass_timeout: got no frame_done want pulse"); end
    digits_in = 16'h9999; load = 1;
    step();
    load = 0;
    tests++;
    if ({bcd_out, digit_sel, digit_idx} !== {4'd9, 4'b0, 2'd0}) begin
      fails++; $display("FAIL bypass: got bcd=%h sel=%b idx=%0d want bcd=9 sel=0000 idx=0", bcd_out, digit_sel, digit_idx);
    end
    for (int i = 0; i < FRAME; i++) begin
      step();
      tests++;
      if (obs() !== exp_v()) begin fails++; $display("FAIL bypass_frame: got %b want %b", obs(), exp_v()); end
    end
  endtask

  task automatic test_enable_drop();
    bit found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      found = digit_idx == 2'd2 && digit_sel != 0;
    end
    tests++;
    if (!found) begin fails++; $display("FAIL drop_timeout: got none want digit 2 SHOW"); end
    enable = 0;
    step();
    tests++;
    if ({digit_sel, busy, frame_done, digit_idx} !== 8'b0) begin
      fails++; $display("FAIL drop: got sel=%b busy=%b fd=%b idx=%0d want all 0", digit_sel, busy, frame_done, digit_idx);
    end
    enable = 1;
    step();
    tests++;
    if ({digit_sel, digit_idx, busy, bcd_out} !== {4'b0, 2'd0, 1'b1, 4'h9}) begin
      fails++; $display("FAIL reenable: got sel=%b idx=%0d busy=%b bcd=%h want 0000 0 1 9", digit_sel, digit_idx, busy, bcd_out);
    end
    for (int i = 0; i < FRAME + 5; i++) begin
      step();
      tests++;
      if (obs() !== exp_v()) begin fails++; $display("FAIL reenable_run: got %b want %b", obs(), exp_v()); end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      found = digit_sel != 0;
    end
    reset = 1;
    step();
    reset = 0;
    tests++;
    if (obs() !== 13'd0) begin fails++; $display("FAIL reset_mid: got %b want 0", obs()); end
    for (int i = 0; i < FRAME + 5; i++) begin
      step();
      tests++;
      if (obs() !== exp_v()) begin fails++; $display("FAIL reset_resume: got %b want %b", obs(), exp_v()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) enable = !enable;
      load = $urandom_range(0, 9) == 0;
      digits_in = 16'($urandom);
      if ($urandom_range(0, 3) == 0) digits_in = digits_in & 16'h00FF;
      reset = $urandom_range(0, 299) == 0;
      step();
      tests++;
      if (obs() !== exp_v()) begin fails++; $display("FAIL random: got %b want %b", obs(), exp_v()); end
    end
    reset = 0; load = 0; enable = 1;
  endtask

`ifdef BCD_SCAN_LZ_BLANK_EN
  task automatic test_lz();
    logic [15:0] vals [3] = '{16'h0045, 16'h0000, 16'h1000};
    logic [3:0] want [3] = '{4'b0011, 4'b0001, 4'b1111};
    logic [3:0] seen;
    for (int v = 0; v < 3; v++) begin
      enable = 0; step();
      digits_in = vals[v]; load = 1; step();
      load = 0; enable = 1; seen = '0;
      for (int i = 0; i < 2 * FRAME + 1; i++) begin
        step();
        seen |= digit_sel;
        tests++;
        if (obs() !== exp_v()) begin fails++; $display("FAIL lz_run %h: got %b want %b", vals[v], obs(), exp_v()); end
      end
      tests++;
      if (seen !== want[v]) begin fails++; $display("FAIL lz_digits %h: got %b want %b", vals[v], seen, want[v]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_midframe_load();
    test_bypass();
    test_enable_drop();
    test_reset_mid();
    test_random();
`ifdef BCD_SCAN_LZ_BLANK_EN
    test_lz();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
